// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the multi-port ARM register file: default register
// width, select width, the program counter index and the offset added when
// the PC is read through a read port, plus the pending-vector type.
//
// Build option: define REG_FILE_BYPASS_EN to enable same-cycle write
// forwarding on the read ports (see reg_file_rd_port).
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_ADDR_W      = 4;
    localparam int DEFAULT_NUM_REGS    = 2 ** DEFAULT_ADDR_W;
    localparam int DEFAULT_PC_IDX      = 15;
    localparam int DEFAULT_PC_READ_OFS = 8;

    // One bit per architectural register; set while a load is outstanding.
    typedef logic [DEFAULT_NUM_REGS-1:0] pend_vec_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// -----------------------------------------------------------------------------
// reg_file_rd_port
// One combinational read port of the register file. Selects a register,
// adds PC_READ_OFS when the PC is selected, and reports whether the selected
// register has a load outstanding.
//
// Build option REG_FILE_BYPASS_EN: when defined, same-cycle write data is
// forwarded (wr1 > wr0 > pc_en) and a returning load (wr1) hides the busy
// flag unless a new load is issued to the same register in the same cycle.
//
// Ports:
//   rd_sel_i      register select
//   regFile_i     registered contents of all registers
//   pend_i        registered pending vector
//   wr0_*_i       ALU write port (forwarding only)
//   wr1_*_i       load/writeback port (forwarding only)
//   pc_*_i        sequential PC update (forwarding only)
//   pend_*_i      load-issue request (busy forwarding only)
//   rd_data_o     read data
//   rd_busy_o     selected register is pending
// -----------------------------------------------------------------------------
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int PC_IDX      = DEFAULT_PC_IDX,
    parameter int PC_READ_OFS = DEFAULT_PC_READ_OFS,
    localparam int NUM_REGS   = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]               rd_sel_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regFile_i,
    input  logic [NUM_REGS-1:0]             pend_i,
    input  logic                            wr0_en_i,
    input  logic [ADDR_W-1:0]               wr0_sel_i,
    input  logic [DATA_W-1:0]               wr0_data_i,
    input  logic                            wr1_en_i,
    input  logic [ADDR_W-1:0]               wr1_sel_i,
    input  logic [DATA_W-1:0]               wr1_data_i,
    input  logic                            pc_en_i,
    input  logic [DATA_W-1:0]               pc_data_i,
    input  logic                            pend_en_i,
    input  logic [ADDR_W-1:0]               pend_sel_i,
    output logic [DATA_W-1:0]               rd_data_o,
    output logic                            rd_busy_o
);

    localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] rawData;

    // Pick the register contents (or the in-flight write when forwarding is
    // built in) and the busy flag for the selected register. The ordering of
    // the forwarding overrides gives wr1 the last word, then wr0, then pc_en.
    always_comb begin
        rawData   = regFile_i[rd_sel_i];
        rd_busy_o = pend_i[rd_sel_i];
`ifdef REG_FILE_BYPASS_EN
        if (pc_en_i && (rd_sel_i == PC_SEL)) begin
            rawData = pc_data_i;
        end
        if (wr0_en_i && (wr0_sel_i == rd_sel_i)) begin
            rawData = wr0_data_i;
        end
        if (wr1_en_i && (wr1_sel_i == rd_sel_i)) begin
            rawData = wr1_data_i;
            if (!(pend_en_i && (pend_sel_i == rd_sel_i))) begin
                rd_busy_o = 1'b0;
            end
        end
`endif
    end

    // The PC is presented to the datapath with its pipeline read offset;
    // the add wraps naturally at DATA_W bits.
    always_comb begin
        rd_data_o = rawData;
        if (rd_sel_i == PC_SEL) begin
            rd_data_o = rawData + DATA_W'(PC_READ_OFS);
        end
    end

`ifndef REG_FILE_BYPASS_EN
    logic unusedBypass;
    assign unusedBypass = ^{wr0_en_i, wr0_sel_i, wr0_data_i,
                            wr1_en_i, wr1_sel_i, wr1_data_i,
                            pc_en_i, pc_data_i, pend_en_i, pend_sel_i};
`endif

endmodule : reg_file_rd_port

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Multi-port ARM register file: three combinational read ports, two write
// ports (wr0 = ALU, wr1 = load/writeback), a sequential PC update port and a
// per-register pending-load scoreboard with a running pending count.
//
// Build option: REG_FILE_BYPASS_EN enables same-cycle forwarding on the read
// ports; without it reads always show registered state.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_sel_[abc]               read selects
//   rd_data_[abc]              read data (PC reads include PC_READ_OFS)
//   rd_busy_[abc]              selected register has a load pending
//   wr0_en/sel/data            ALU write port
//   wr1_en/sel/data            load/writeback port, clears pending bit
//   pc_en, pc_data             sequential PC update from fetch
//   pend_en, pend_sel          mark register pending (load issued)
//   pc_q                       raw PC contents
//   pend_count                 number of registers pending
// -----------------------------------------------------------------------------
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int PC_IDX      = DEFAULT_PC_IDX,
    parameter int PC_READ_OFS = DEFAULT_PC_READ_OFS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_sel_a,
    input  logic [ADDR_W-1:0] rd_sel_b,
    input  logic [ADDR_W-1:0] rd_sel_c,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              rd_busy_c,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_sel,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_sel,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              pc_en,
    input  logic [DATA_W-1:0] pc_data,
    input  logic              pend_en,
    input  logic [ADDR_W-1:0] pend_sel,
    output logic [DATA_W-1:0] pc_q,
    output logic [ADDR_W:0]   pend_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);

    logic [NUM_REGS-1:0][DATA_W-1:0] regFile_q, regFile_d;
    logic [NUM_REGS-1:0]             pend_q, pend_d;
    logic [CNT_W-1:0]                pendCount_q, pendCount_d;
    logic                            setOk, incr, decr;

    // Next register contents. Assignments are ordered lowest priority first
    // so that wr1 beats wr0 beats the sequential PC update on a shared target
    // (a branch writing r15 therefore wins over fetch).
    always_comb begin
        regFile_d = regFile_q;
        if (pc_en) begin
            regFile_d[PC_IDX] = pc_data;
        end
        if (wr0_en) begin
            regFile_d[wr0_sel] = wr0_data;
        end
        if (wr1_en) begin
            regFile_d[wr1_sel] = wr1_data;
        end
    end

    // Pending scoreboard. A returning load clears its bit, a newly issued
    // load sets it, and set wins on the same register. The PC can never be
    // pending. The count moves by at most one per cycle: it only rises when a
    // set lands on a clear bit and only falls when a clear really removes a
    // bit that is not immediately re-set.
    always_comb begin
        setOk  = pend_en && (pend_sel != PC_SEL);
        pend_d = pend_q;
        if (wr1_en) begin
            pend_d[wr1_sel] = 1'b0;
        end
        if (setOk) begin
            pend_d[pend_sel] = 1'b1;
        end
        incr = setOk && !pend_q[pend_sel];
        decr = wr1_en && pend_q[wr1_sel] && !(setOk && (pend_sel == wr1_sel));
        pendCount_d = pendCount_q + CNT_W'(incr) - CNT_W'(decr);
    end

    // State registers; reset discards every write and pend request in the
    // same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            regFile_q   <= '0;
            pend_q      <= '0;
            pendCount_q <= '0;
        end else begin
            regFile_q   <= regFile_d;
            pend_q      <= pend_d;
            pendCount_q <= pendCount_d;
        end
    end

    assign pc_q       = regFile_q[PC_IDX];
    assign pend_count = pendCount_q;

    logic [2:0][ADDR_W-1:0] rdSel;
    logic [2:0][DATA_W-1:0] rdData;
    logic [2:0]             rdBusy;

    assign rdSel = {rd_sel_c, rd_sel_b, rd_sel_a};

    // Three identical read ports.
    for (genvar p = 0; p < 3; p++) begin : gRdPort
        reg_file_rd_port #(
            .DATA_W      (DATA_W),
            .ADDR_W      (ADDR_W),
            .PC_IDX      (PC_IDX),
            .PC_READ_OFS (PC_READ_OFS)
        ) uRdPort (
            .rd_sel_i   (rdSel[p]),
            .regFile_i  (regFile_q),
            .pend_i     (pend_q),
            .wr0_en_i   (wr0_en),
            .wr0_sel_i  (wr0_sel),
            .wr0_data_i (wr0_data),
            .wr1_en_i   (wr1_en),
            .wr1_sel_i  (wr1_sel),
            .wr1_data_i (wr1_data),
            .pc_en_i    (pc_en),
            .pc_data_i  (pc_data),
            .pend_en_i  (pend_en),
            .pend_sel_i (pend_sel),
            .rd_data_o  (rdData[p]),
            .rd_busy_o  (rdBusy[p])
        );
    end

    assign rd_data_a = rdData[0];
    assign rd_data_b = rdData[1];
    assign rd_data_c = rdData[2];
    assign rd_busy_a = rdBusy[0];
    assign rd_busy_b = rdBusy[1];
    assign rd_busy_c = rdBusy[2];

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Directed, self-checking bench for reg_file_mp. Expected values are queued
// when stimulus is driven and popped when the DUT outputs are sampled.
// Expectations that depend on forwarding follow REG_FILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic [3:0]  rd_sel_a, rd_sel_b, rd_sel_c;
    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_busy_a, rd_busy_b, rd_busy_c;
    logic        wr0_en, wr1_en, pc_en, pend_en;
    logic [3:0]  wr0_sel, wr1_sel, pend_sel;
    logic [31:0] wr0_data, wr1_data, pc_data;
    logic [31:0] pc_q;
    logic [4:0]  pend_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expQ[$];
    string       tagQ[$];

    reg_file_mp dut (
        .clk        (clk),
        .reset      (reset),
        .rd_sel_a   (rd_sel_a),
        .rd_sel_b   (rd_sel_b),
        .rd_sel_c   (rd_sel_c),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_data_c  (rd_data_c),
        .rd_busy_a  (rd_busy_a),
        .rd_busy_b  (rd_busy_b),
        .rd_busy_c  (rd_busy_c),
        .wr0_en     (wr0_en),
        .wr0_sel    (wr0_sel),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_sel    (wr1_sel),
        .wr1_data   (wr1_data),
        .pc_en      (pc_en),
        .pc_data    (pc_data),
        .pend_en    (pend_en),
        .pend_sel   (pend_sel),
        .pc_q       (pc_q),
        .pend_count (pend_count)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic w0e, input logic [3:0] w0s, input logic [31:0] w0d,
                                 input logic w1e, input logic [3:0] w1s, input logic [31:0] w1d,
                                 input logic pce, input logic [31:0] pcd,
                                 input logic pe, input logic [3:0] ps);
        wr0_en = w0e; wr0_sel = w0s; wr0_data = w0d;
        wr1_en = w1e; wr1_sel = w1s; wr1_data = w1d;
        pc_en  = pce; pc_data = pcd;
        pend_en = pe; pend_sel = ps;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic selects(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        rd_sel_a = a; rd_sel_b = b; rd_sel_c = c;
        #1;
    endtask

    task automatic expectVal(input string tag, input logic [31:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        logic [31:0] expected;
        string       tag;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_underflow observed=%h expected=<none>", observed);
        end else begin
            expected = expQ.pop_front();
            tag      = tagQ.pop_front();
            assert (observed === expected) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd_sel_a = 4'd0; rd_sel_b = 4'd0; rd_sel_c = 4'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state: every register reads 0, the PC reads its offset.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            expectVal($sformatf("rst_data_r%0d", i), (i == 15) ? 32'h8 : 32'h0);
            expectVal($sformatf("rst_busy_r%0d", i), 32'h0);
            selects(4'(i), 4'd0, 4'd0);
            checkOutput(rd_data_a);
            checkOutput({31'd0, rd_busy_a});
        end
        expectVal("rst_pc_q", 32'h0);
        expectVal("rst_pend_count", 32'h0);
        checkOutput(pc_q);
        checkOutput({27'd0, pend_count});

        // wr1 beats wr0 on the same register.
        applyStimulus(1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22, 1'b0, 32'd0, 1'b0, 4'd0);
        expectVal("prio_wr1_r3", 32'h22);
        tick();
        idle();
        selects(4'd3, 4'd0, 4'd0);
        checkOutput(rd_data_a);

        // Writes to different registers both land.
        applyStimulus(1'b1, 4'd4, 32'h33, 1'b1, 4'd3, 32'h44, 1'b0, 32'd0, 1'b0, 4'd0);
        expectVal("dual_wr1_r3", 32'h44);
        expectVal("dual_wr0_r4", 32'h33);
        tick();
        idle();
        selects(4'd0, 4'd3, 4'd4);
        checkOutput(rd_data_b);
        checkOutput(rd_data_c);

        // Branch write to r15 beats sequential fetch.
        applyStimulus(1'b1, 4'd15, 32'h200, 1'b0, 4'd0, 32'd0, 1'b1, 32'h100, 1'b0, 4'd0);
        expectVal("branch_pc_q", 32'h200);
        expectVal("branch_r15_read", 32'h208);
        tick();
        idle();
        selects(4'd15, 4'd0, 4'd0);
        checkOutput(pc_q);
        checkOutput(rd_data_a);

        // wr1 beats wr0 and pc_en on r15.
        applyStimulus(1'b1, 4'd15, 32'h400, 1'b1, 4'd15, 32'h300, 1'b1, 32'h500, 1'b0, 4'd0);
        expectVal("pc_wr1_prio", 32'h300);
        tick();
        idle();
        checkOutput(pc_q);

        // Sequential PC update, read offset wraps.
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 4'd0);
        expectVal("pc_wrap_pc_q", 32'hFFFF_FFFC);
        expectVal("pc_wrap_read", 32'h4);
        tick();
        idle();
        selects(4'd0, 4'd15, 4'd0);
        checkOutput(pc_q);
        checkOutput(rd_data_b);

        // Pending r5: not visible until the next edge.
        selects(4'd5, 4'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd5);
        #1;
        expectVal("pend_r5_before_edge", 32'h0);
        checkOutput({31'd0, rd_busy_a});
        expectVal("pend_r5_busy", 32'h1);
        expectVal("pend_r5_count", 32'h1);
        tick();
        idle();
        #1;
        checkOutput({31'd0, rd_busy_a});
        checkOutput({27'd0, pend_count});

        // Load returns to r5.
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hAB, 1'b0, 32'd0, 1'b0, 4'd0);
        expectVal("ret_r5_busy", 32'h0);
        expectVal("ret_r5_count", 32'h0);
        expectVal("ret_r5_data", 32'hAB);
        tick();
        idle();
        #1;
        checkOutput({31'd0, rd_busy_a});
        checkOutput({27'd0, pend_count});
        checkOutput(rd_data_a);

        // Pend r5 again, then return and re-issue in one cycle: set wins.
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd5);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hCD, 1'b0, 32'd0, 1'b1, 4'd5);
        expectVal("setwins_busy", 32'h1);
        expectVal("setwins_count", 32'h1);
        expectVal("setwins_data", 32'hCD);
        tick();
        idle();
        #1;
        checkOutput({31'd0, rd_busy_a});
        checkOutput({27'd0, pend_count});
        checkOutput(rd_data_a);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hCE, 1'b0, 32'd0, 1'b0, 4'd0);
        expectVal("clear_r5_count", 32'h0);
        tick();
        idle();
        #1;
        checkOutput({27'd0, pend_count});

        // r1, r2, r1 again; r15 ignored; clear of non-pending r6 ignored.
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd2);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd1);
        expectVal("repend_count", 32'h2);
        tick();
        idle();
        #1;
        checkOutput({27'd0, pend_count});
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h66, 1'b0, 32'd0, 1'b1, 4'd15);
        expectVal("pc_pend_ignored_count", 32'h2);
        expectVal("pc_pend_ignored_busy", 32'h0);
        expectVal("busy_r1", 32'h1);
        expectVal("busy_r2", 32'h1);
        tick();
        idle();
        selects(4'd15, 4'd1, 4'd2);
        checkOutput({27'd0, pend_count});
        checkOutput({31'd0, rd_busy_a});
        checkOutput({31'd0, rd_busy_b});
        checkOutput({31'd0, rd_busy_c});

        // Reset with a write and a pend request active.
        reset = 1'b1;
        applyStimulus(1'b1, 4'd8, 32'h77, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd9);
        expectVal("rst2_count", 32'h0);
        expectVal("rst2_busy_r1", 32'h0);
        expectVal("rst2_busy_r2", 32'h0);
        expectVal("rst2_busy_r9", 32'h0);
        expectVal("rst2_data_r8", 32'h0);
        expectVal("rst2_data_r3", 32'h0);
        expectVal("rst2_pc_q", 32'h0);
        tick();
        reset = 1'b0;
        idle();
        selects(4'd1, 4'd2, 4'd9);
        checkOutput({27'd0, pend_count});
        checkOutput({31'd0, rd_busy_a});
        checkOutput({31'd0, rd_busy_b});
        checkOutput({31'd0, rd_busy_c});
        selects(4'd8, 4'd3, 4'd0);
        checkOutput(rd_data_a);
        checkOutput(rd_data_b);
        checkOutput(pc_q);

        // Same-cycle read of a register being written.
        selects(4'd7, 4'd0, 4'd15);
        applyStimulus(1'b1, 4'd7, 32'h5A, 1'b0, 4'd0, 32'd0, 1'b1, 32'h40, 1'b0, 4'd0);
        #1;
`ifdef REG_FILE_BYPASS_EN
        expectVal("same_cycle_r7", 32'h5A);
        expectVal("same_cycle_pc", 32'h48);
`else
        expectVal("same_cycle_r7", 32'h0);
        expectVal("same_cycle_pc", 32'h8);
`endif
        checkOutput(rd_data_a);
        checkOutput(rd_data_c);
        expectVal("next_cycle_r7", 32'h5A);
        expectVal("next_cycle_pc", 32'h48);
        tick();
        idle();
        #1;
        checkOutput(rd_data_a);
        checkOutput(rd_data_c);

        // Same-cycle busy forwarding on a returning load.
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd10);
        tick();
        selects(4'd0, 4'd10, 4'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd10, 32'h1234, 1'b0, 32'd0, 1'b0, 4'd0);
        #1;
`ifdef REG_FILE_BYPASS_EN
        expectVal("same_cycle_busy_r10", 32'h0);
        expectVal("same_cycle_data_r10", 32'h1234);
`else
        expectVal("same_cycle_busy_r10", 32'h1);
        expectVal("same_cycle_data_r10", 32'h0);
`endif
        checkOutput({31'd0, rd_busy_b});
        checkOutput(rd_data_b);
        expectVal("next_cycle_busy_r10", 32'h0);
        expectVal("next_cycle_count", 32'h0);
        tick();
        idle();
        #1;
        checkOutput({31'd0, rd_busy_b});
        checkOutput({27'd0, pend_count});

        checks++;
        assert (expQ.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_mp

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port ARM register file for the 32-bit core: three combinational read ports, two synchronous write ports (ALU result and load/base writeback), a dedicated PC update port, and a per-register pending-load scoreboard. It replaces the single-write/dual-read register file in the decode/writeback stage. It lets the pipeline issue a load and stall consumers of its destination until the data returns.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, select width; NUM_REGS = 2**ADDR_W
- PC_IDX, 15, index of the program counter register
- PC_READ_OFS, 8, value added to the PC contents when PC_IDX is read through a read port

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_sel_a / rd_sel_b / rd_sel_c  in  ADDR_W  read selects
- rd_data_a / rd_data_b / rd_data_c  out  DATA_W  read data
- rd_busy_a / rd_busy_b / rd_busy_c  out  1  selected register has a load pending
- wr0_en, wr0_sel, wr0_data  in  1/ADDR_W/DATA_W  ALU write port
- wr1_en, wr1_sel, wr1_data  in  1/ADDR_W/DATA_W  load/writeback port; also clears the pending bit
- pc_en, pc_data  in  1/DATA_W  sequential PC update from fetch
- pend_en, pend_sel  in  1/ADDR_W  mark register pending (load issued)
- pc_q  out  DATA_W  raw PC register contents, no offset
- pend_count  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: NUM_REGS x DATA_W registers plus a NUM_REGS-bit pending vector.
- Reads are combinational. A read of PC_IDX returns pc_q + PC_READ_OFS, mod 2**DATA_W. Other indices return raw contents.
- rd_busy_x = pending[rd_sel_x]. PC_IDX is never pending: pend_en with pend_sel == PC_IDX is ignored.
- Write priority, same target in same cycle: wr1 > wr0 > pc_en. Any wr0/wr1 write to PC_IDX overrides pc_en (branch wins over sequential fetch).
- Writes to different targets in the same cycle all take effect.
- Pending update per cycle:
  - wr1_en clears pending[wr1_sel].
  - pend_en sets pending[pend_sel].
  - If both hit the same register, set wins (a new load is issued behind the returning one).
- wr0 does not touch pending bits.
- pend_count is a registered popcount of the next pending vector. It is maintained incrementally (+1, -1 or 0 per cycle). No change when a set targets an already-pending register or a clear targets a non-pending one.
- Reset: all registers 0, pc_q 0, pending 0, pend_count 0. Reset overrides every write and pend request in that cycle.

## Timing
- Read latency 0 (combinational from select and state).
- Write latency 1 cycle: data written at edge N is visible on read ports after edge N.
- Pending bit changes become visible on rd_busy and pend_count one cycle after the request.
- All outputs after reset edge: rd_data_x = 0 (PC_IDX reads PC_READ_OFS), rd_busy_x = 0, pc_q = 0, pend_count = 0.

## Configuration
- REG_FILE_BYPASS_EN: when defined, each read port forwards same-cycle write data using the same priority (wr1 > wr0 > pc_en). PC_READ_OFS is still applied on PC_IDX. rd_busy_x is forced 0 when wr1_en writes rd_sel_x in that cycle, unless pend_en sets the same register.
- When undefined: no forwarding. Reads always reflect registered state, and write latency is 1 cycle.

## Structure
- Package reg_file_pkg: default DATA_W/ADDR_W, PC_IDX and PC_READ_OFS constants, and a typedef for the pending-vector width.
- Sub-module reg_file_rd_port: one read port (mux, PC offset, optional bypass, busy lookup), instantiated three times.

## Test plan
- Reset, then read all 16 → data 0, r15 reads 0x8, busy 0, pend_count 0.
- Same-cycle write: wr0 r3=0x11 and wr1 r3=0x22 → r3 reads 0x22 next cycle. Same cycle with wr0 r4=0x33 → r4 = 0x33.
- pc_en pc_data=0x100 and wr0 r15=0x200 in the same cycle → pc_q = 0x200, read r15 = 0x208. pc_data = 0xFFFFFFFC alone → read r15 = 0x4 (wrap).
- pend r5 → rd_busy 1, pend_count 1. wr1 r5=0xAB → busy 0, count 0, data 0xAB. pend r5 and wr1 r5 in the same cycle → busy stays 1, count 1.
- Pend r1, r2, r1 again → pend_count 2. pend r15 → ignored. Reset while r1 and r2 are pending, with wr0 active → all cleared, write discarded.
- With REG_FILE_BYPASS_EN: wr0 r7=0x5A while reading r7 → 0x5A in the same cycle. Without the macro: old value in that cycle, 0x5A in the next.
